// File: rtl/riscv_instr_loader_if.sv
// ---------------------------------------------------------------------------
// riscv_instr_loader_if
//
// Purpose:
//   Groups the byte-serial instruction configuration stream and the 32-bit
//   instruction-memory write port that the loader sits between.
//
// Signals:
//   instr_config_addr   byte address of the incoming config byte
//   instr_config_din    config byte
//   instr_config_wr_en  byte valid, one byte per cycle, no backpressure
//   mem_addr            word address of a memory write
//   mem_wdata           packed write data
//   mem_wstrb           byte-lane enables, bit i covers bits [8i+7:8i]
//   mem_we              one-cycle write pulse
//
// Modports:
//   master  environment side: drives the config stream, observes the writes
//   slave   loader side: consumes the config stream, drives the writes
// ---------------------------------------------------------------------------
interface riscv_instr_loader_if #(
  parameter int CFG_ADDR_BITS = 24,
  parameter int MEM_ADDR_BITS = 14
);
  logic [CFG_ADDR_BITS-1:0] instr_config_addr;
  logic [7:0]               instr_config_din;
  logic                     instr_config_wr_en;
  logic [MEM_ADDR_BITS-1:0] mem_addr;
  logic [31:0]              mem_wdata;
  logic [3:0]               mem_wstrb;
  logic                     mem_we;

  modport master (
    output instr_config_addr, instr_config_din, instr_config_wr_en,
    input  mem_addr, mem_wdata, mem_wstrb, mem_we
  );

  modport slave (
    input  instr_config_addr, instr_config_din, instr_config_wr_en,
    output mem_addr, mem_wdata, mem_wstrb, mem_we
  );
endinterface

// File: rtl/riscv_instr_loader.sv
// ---------------------------------------------------------------------------
// riscv_instr_loader
//
// Purpose:
//   Packs a byte-serial instruction stream into 32-bit word writes with byte
//   strobes for the picorv32 instruction memory, and sequences the core reset
//   so the core only runs once an image has been loaded, has gone quiet, and
//   ap_start is high.
//
// Ports:
//   clk          user clock, single clock domain
//   resetn       asynchronous active-low reset
//   bus          slave modport: config byte stream in, memory writes out
//   ap_start     run request from host
//   core_resetn  active-low reset to picorv32
//   load_done    image loaded and settled
//   byte_count   accepted bytes since reset, saturating
//   addr_err     sticky; an out-of-range byte was dropped
//
// The bus interface instance must use the same CFG_ADDR_BITS/MEM_ADDR_BITS
// as this module.
// ---------------------------------------------------------------------------
module riscv_instr_loader #(
  parameter int CFG_ADDR_BITS = 24,
  parameter int MEM_ADDR_BITS = 14,
  parameter int IDLE_CYCLES   = 16,
  parameter int CNT_BITS      = 24
) (
  input  logic                clk,
  input  logic                resetn,
  riscv_instr_loader_if.slave bus,
  input  logic                ap_start,
  output logic                core_resetn,
  output logic                load_done,
  output logic [CNT_BITS-1:0] byte_count,
  output logic                addr_err
);

  localparam int IDLE_W    = $clog2(IDLE_CYCLES + 1);
  localparam int HALF_IDLE = IDLE_CYCLES / 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // Incoming byte decode
  // -------------------------------------------------------------------------
  logic                     w_out_of_range;
  logic                     w_accept;
  logic [1:0]               w_lane;
  logic [MEM_ADDR_BITS-1:0] w_word;
  logic [3:0]               w_lane_hit;
  logic                     w_same_word;
  logic [3:0]               w_base_strb;
  logic [31:0]              w_base_data;
  logic [3:0]               w_merge_strb;
  logic [31:0]              w_merge_data;

  generate
    if (CFG_ADDR_BITS > MEM_ADDR_BITS + 2) begin : g_hi_bits
      assign w_out_of_range = |bus.instr_config_addr[CFG_ADDR_BITS-1:MEM_ADDR_BITS+2];
    end else begin : g_no_hi_bits
      assign w_out_of_range = 1'b0;
    end
  endgenerate

  assign w_accept = bus.instr_config_wr_en & ~w_out_of_range;
  assign w_lane   = bus.instr_config_addr[1:0];
  assign w_word   = bus.instr_config_addr[MEM_ADDR_BITS+1:2];

  // Staging registers
  logic                     r_stg_valid;
  logic [MEM_ADDR_BITS-1:0] r_stg_addr;
  logic [31:0]              r_stg_data;
  logic [3:0]               r_stg_strb;

  // A byte for a fresh word starts from a zeroed base so unwritten lanes
  // never carry stale data from a previous word.
  assign w_same_word = r_stg_valid && (r_stg_addr == w_word);
  assign w_base_strb = w_same_word ? r_stg_strb : 4'b0000;
  assign w_base_data = w_same_word ? r_stg_data : 32'h0000_0000;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lane_hit[gi]          = (w_lane == 2'(gi));
      assign w_merge_data[8*gi +: 8] = w_lane_hit[gi] ? bus.instr_config_din
                                                      : w_base_data[8*gi +: 8];
    end
  endgenerate

  assign w_merge_strb = w_base_strb | w_lane_hit;

  // -------------------------------------------------------------------------
  // Datapath next-state
  // -------------------------------------------------------------------------
  logic                     w_stg_valid_next;
  logic [MEM_ADDR_BITS-1:0] w_stg_addr_next;
  logic [31:0]              w_stg_data_next;
  logic [3:0]               w_stg_strb_next;

  logic                     r_mem_we;
  logic [MEM_ADDR_BITS-1:0] r_mem_addr;
  logic [31:0]              r_mem_wdata;
  logic [3:0]               r_mem_wstrb;
  logic                     w_mem_we_next;
  logic [MEM_ADDR_BITS-1:0] w_mem_addr_next;
  logic [31:0]              w_mem_wdata_next;
  logic [3:0]               w_mem_wstrb_next;

  logic [IDLE_W-1:0]        r_idle;
  logic [IDLE_W-1:0]        w_idle_next;
  logic [CNT_BITS-1:0]      r_byte_count;
  logic [CNT_BITS-1:0]      w_byte_count_next;
  logic                     r_addr_err;
  logic                     w_addr_err_next;

  always_comb begin
    w_stg_valid_next = r_stg_valid;
    w_stg_addr_next  = r_stg_addr;
    w_stg_data_next  = r_stg_data;
    w_stg_strb_next  = r_stg_strb;
    w_mem_we_next    = 1'b0;
    w_mem_addr_next  = r_mem_addr;
    w_mem_wdata_next = r_mem_wdata;
    w_mem_wstrb_next = r_mem_wstrb;

    if (w_accept) begin
      if (r_stg_valid && !w_same_word) begin
        // Word change: push out the old stage and start the new one in the
        // same cycle. A single byte can never fill a stage, so no second flush.
        w_mem_we_next    = 1'b1;
        w_mem_addr_next  = r_stg_addr;
        w_mem_wdata_next = r_stg_data;
        w_mem_wstrb_next = r_stg_strb;
        w_stg_valid_next = 1'b1;
        w_stg_addr_next  = w_word;
        w_stg_data_next  = w_merge_data;
        w_stg_strb_next  = w_merge_strb;
      end else if (w_merge_strb == 4'hF) begin
        // Completing byte goes straight out with the rest of the word.
        w_mem_we_next    = 1'b1;
        w_mem_addr_next  = w_word;
        w_mem_wdata_next = w_merge_data;
        w_mem_wstrb_next = 4'hF;
        w_stg_valid_next = 1'b0;
        w_stg_strb_next  = 4'b0000;
      end else begin
        w_stg_valid_next = 1'b1;
        w_stg_addr_next  = w_word;
        w_stg_data_next  = w_merge_data;
        w_stg_strb_next  = w_merge_strb;
      end
    end else if (!bus.instr_config_wr_en && r_stg_valid &&
                 (r_idle == IDLE_W'(HALF_IDLE))) begin
      // Stream went quiet with a partial word pending: write what we have.
      w_mem_we_next    = 1'b1;
      w_mem_addr_next  = r_stg_addr;
      w_mem_wdata_next = r_stg_data;
      w_mem_wstrb_next = r_stg_strb;
      w_stg_valid_next = 1'b0;
      w_stg_strb_next  = 4'b0000;
    end
  end

  always_comb begin
    w_idle_next       = r_idle;
    w_byte_count_next = r_byte_count;
    w_addr_err_next   = r_addr_err;

    // Any wr_en, even a dropped one, counts as activity on the stream.
    if (bus.instr_config_wr_en) begin
      w_idle_next = '0;
    end else if (r_idle != IDLE_W'(IDLE_CYCLES)) begin
      w_idle_next = r_idle + IDLE_W'(1);
    end

    if (w_accept && !(&r_byte_count)) begin
      w_byte_count_next = r_byte_count + CNT_BITS'(1);
    end

    if (bus.instr_config_wr_en && w_out_of_range) begin
      w_addr_err_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stg_valid  <= 1'b0;
      r_stg_addr   <= '0;
      r_stg_data   <= '0;
      r_stg_strb   <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_wstrb  <= '0;
      r_idle       <= '0;
      r_byte_count <= '0;
      r_addr_err   <= 1'b0;
    end else begin
      r_stg_valid  <= w_stg_valid_next;
      r_stg_addr   <= w_stg_addr_next;
      r_stg_data   <= w_stg_data_next;
      r_stg_strb   <= w_stg_strb_next;
      r_mem_we     <= w_mem_we_next;
      r_mem_addr   <= w_mem_addr_next;
      r_mem_wdata  <= w_mem_wdata_next;
      r_mem_wstrb  <= w_mem_wstrb_next;
      r_idle       <= w_idle_next;
      r_byte_count <= w_byte_count_next;
      r_addr_err   <= w_addr_err_next;
    end
  end

  // -------------------------------------------------------------------------
  // Load / run sequencing
  // -------------------------------------------------------------------------
  state_t r_state;
  state_t w_state_next;
  logic   r_core_resetn;
  logic   r_load_done;
  logic   w_core_resetn_next;
  logic   w_load_done_next;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_core_resetn <= 1'b0;
      r_load_done   <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_core_resetn <= w_core_resetn_next;
      r_load_done   <= w_load_done_next;
    end
  end

  // A new byte always wins over ap_start: the core must not run on an image
  // that is being rewritten.
  always_comb begin
    w_state_next = r_state;

    unique case (r_state)
      S_IDLE: begin
        if (bus.instr_config_wr_en) w_state_next = S_LOAD;
      end
      S_LOAD: begin
        if (!bus.instr_config_wr_en && !r_stg_valid &&
            (r_idle == IDLE_W'(IDLE_CYCLES))) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.instr_config_wr_en) w_state_next = S_LOAD;
        else if (ap_start)          w_state_next = S_RUN;
      end
      S_RUN: begin
        if (bus.instr_config_wr_en) w_state_next = S_LOAD;
        else if (!ap_start)         w_state_next = S_DONE;
      end
      default: w_state_next = S_IDLE;
    endcase

    // Outputs are registered from the next state so they change together
    // with the state register.
    w_load_done_next   = (w_state_next == S_DONE) || (w_state_next == S_RUN);
    w_core_resetn_next = (w_state_next == S_RUN);
  end

  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_wstrb = r_mem_wstrb;
  assign core_resetn   = r_core_resetn;
  assign load_done     = r_load_done;
  assign byte_count    = r_byte_count;
  assign addr_err      = r_addr_err;

endmodule

// File: tb/tb_riscv_instr_loader.sv
// ---------------------------------------------------------------------------
// tb_riscv_instr_loader
//
// Directed steps from the test plan followed by randomized bursts. Expected
// outputs come from a word-level reference model: pending word + byte mask,
// a run-length of quiet cycles, and the rule that the core runs only while a
// settled image exists and ap_start is held.
// ---------------------------------------------------------------------------
module tb_riscv_instr_loader;
  localparam int CFG  = 24;
  localparam int MEM  = 14;
  localparam int IDLE = 16;
  localparam int CNTB = 24;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            ap_start = 1'b0;
  logic            core_resetn;
  logic            load_done;
  logic            addr_err;
  logic [CNTB-1:0] byte_count;

  riscv_instr_loader_if #(.CFG_ADDR_BITS(CFG), .MEM_ADDR_BITS(MEM)) bus_if ();

  riscv_instr_loader #(
    .CFG_ADDR_BITS(CFG),
    .MEM_ADDR_BITS(MEM),
    .IDLE_CYCLES  (IDLE),
    .CNT_BITS     (CNTB)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .bus        (bus_if),
    .ap_start   (ap_start),
    .core_resetn(core_resetn),
    .load_done  (load_done),
    .byte_count (byte_count),
    .addr_err   (addr_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit              m_seen;
  int              m_quiet;
  int              m_cnt;
  bit              m_err;
  bit              m_pend;
  int unsigned     m_pword;
  logic [31:0]     m_pdata;
  logic [3:0]      m_pstrb;
  bit              e_we;
  logic [MEM-1:0]  e_addr;
  logic [31:0]     e_data;
  logic [3:0]      e_strb;
  bit              e_ld;
  bit              e_core;
  bit              prev_ld;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_seen = 0; m_quiet = 0; m_cnt = 0; m_err = 0;
    m_pend = 0; m_pword = 0; m_pdata = '0; m_pstrb = '0;
    e_we = 0; e_addr = '0; e_data = '0; e_strb = '0;
    e_ld = 0; e_core = 0; prev_ld = 0;
  endtask

  task automatic emit(input int unsigned w, input logic [31:0] d, input logic [3:0] s);
    e_we   = 1;
    e_addr = w[MEM-1:0];
    e_data = d;
    e_strb = s;
  endtask

  // Advance the model by one clock edge with the inputs sampled at that edge.
  task automatic model_edge(input bit wr, input logic [CFG-1:0] a, input logic [7:0] d, input bit ap);
    int unsigned word;
    int lane;
    e_we = 0;
    if (wr) begin
      m_quiet = 0;
      m_seen  = 1;
      if ((a >> (MEM + 2)) != 0) begin
        m_err = 1;
      end else begin
        if (m_cnt != (1 << CNTB) - 1) m_cnt++;
        word = a >> 2;
        lane = a % 4;
        if (m_pend && m_pword != word) begin
          emit(m_pword, m_pdata, m_pstrb);
          m_pend = 0;
        end
        if (!m_pend) begin
          m_pword = word; m_pdata = '0; m_pstrb = '0; m_pend = 1;
        end
        m_pdata[lane*8 +: 8] = d;
        m_pstrb[lane] = 1'b1;
        if (m_pstrb == 4'hF) begin
          emit(m_pword, m_pdata, m_pstrb);
          m_pend = 0;
        end
      end
    end else begin
      if (m_quiet < 100000) m_quiet++;
      if (m_quiet == IDLE/2 + 1 && m_pend) begin
        emit(m_pword, m_pdata, m_pstrb);
        m_pend = 0;
      end
    end
    // The image is settled once the stream has been quiet for more than
    // IDLE cycles; the core runs from the cycle after settled + ap_start.
    e_core  = prev_ld && ap && !wr;
    e_ld    = m_seen && (m_quiet >= IDLE + 1);
    prev_ld = e_ld;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_we"},    bus_if.mem_we,    e_we);
    chk({tag, "_addr"},  bus_if.mem_addr,  e_addr);
    chk({tag, "_wdata"}, bus_if.mem_wdata, e_data);
    chk({tag, "_wstrb"}, bus_if.mem_wstrb, e_strb);
    chk({tag, "_done"},  load_done,        e_ld);
    chk({tag, "_core"},  core_resetn,      e_core);
    chk({tag, "_count"}, byte_count,       m_cnt);
    chk({tag, "_err"},   addr_err,         m_err);
  endtask

  task automatic step(input string tag, input bit wr, input logic [CFG-1:0] a,
                      input logic [7:0] d, input bit ap);
    @(negedge clk);
    bus_if.instr_config_wr_en = wr;
    bus_if.instr_config_addr  = a;
    bus_if.instr_config_din   = d;
    ap_start = ap;
    @(posedge clk);
    model_edge(wr, a, d, ap);
    #1;
    check_all(tag);
  endtask

  task automatic quiet(input string tag, input int n, input bit ap);
    for (int i = 0; i < n; i++) step(tag, 1'b0, '0, 8'h00, ap);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    bus_if.instr_config_wr_en = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  logic [CFG-1:0] ra;
  bit             rap;
  bit             rwr;
  int             blen;
  int             gap;

  initial begin
    bus_if.instr_config_wr_en = 1'b0;
    bus_if.instr_config_addr  = '0;
    bus_if.instr_config_din   = '0;
    model_reset();

    // Reset state
    #3;
    check_all("reset");
    @(negedge clk);
    resetn = 1'b1;

    // Full word at addresses 0..3
    step("w0", 1'b1, 24'h000000, 8'h13, 1'b0);
    step("w1", 1'b1, 24'h000001, 8'h05, 1'b0);
    step("w2", 1'b1, 24'h000002, 8'h00, 1'b0);
    step("w3", 1'b1, 24'h000003, 8'h00, 1'b0);
    chk("full_we",    bus_if.mem_we,    1'b1);
    chk("full_wdata", bus_if.mem_wdata, 32'h0000_0513);
    chk("full_wstrb", bus_if.mem_wstrb, 4'hF);
    chk("full_count", byte_count,       4);
    quiet("q1", 20, 1'b0);
    chk("q1_done", load_done, 1'b1);

    // Word change flush, then idle flush, then settle
    step("a5", 1'b1, 24'h000005, 8'hAA, 1'b0);
    step("a8", 1'b1, 24'h000008, 8'hBB, 1'b0);
    chk("chg_we",    bus_if.mem_we,           1'b1);
    chk("chg_addr",  bus_if.mem_addr,         1);
    chk("chg_lane",  bus_if.mem_wdata[15:8],  8'hAA);
    chk("chg_wstrb", bus_if.mem_wstrb,        4'b0010);
    quiet("q2", 20, 1'b0);
    chk("idle_addr",  bus_if.mem_addr,  2);
    chk("idle_wstrb", bus_if.mem_wstrb, 4'b0001);

    // Out-of-range byte is dropped
    step("oor", 1'b1, 24'h010000, 8'h55, 1'b0);
    chk("oor_err", addr_err, 1'b1);
    quiet("q3", 20, 1'b0);
    chk("oor_sticky", addr_err, 1'b1);
    chk("oor_count",  byte_count, 6);

    // Run control
    quiet("ap1", 3, 1'b1);
    chk("run_core", core_resetn, 1'b1);
    quiet("ap0", 2, 1'b0);
    quiet("ap1b", 3, 1'b1);

    // Reload while running
    step("reload", 1'b1, 24'h00000C, 8'h77, 1'b1);
    chk("reload_core", core_resetn, 1'b0);
    chk("reload_done", load_done,   1'b0);
    quiet("q4", 20, 1'b1);
    chk("rerun_core", core_resetn, 1'b1);

    // Repeated writes to one lane collapse into one write
    step("r11", 1'b1, 24'h000002, 8'h11, 1'b0);
    step("r22", 1'b1, 24'h000002, 8'h22, 1'b0);
    quiet("q5", 12, 1'b0);
    chk("rep_wstrb", bus_if.mem_wstrb,        4'b0100);
    chk("rep_lane",  bus_if.mem_wdata[23:16], 8'h22);

    // Reset with a partial word staged discards it
    step("s33", 1'b1, 24'h000002, 8'h33, 1'b0);
    async_reset("midrst");
    quiet("q6", 20, 1'b0);

    // Randomized bursts
    rap = 1'b0;
    for (int r = 0; r < 60; r++) begin
      blen = $urandom_range(1, 10);
      for (int k = 0; k < blen; k++) begin
        ra = CFG'($urandom_range(0, 47));
        if ($urandom_range(0, 15) == 0) ra[MEM + 2 + $urandom_range(0, CFG - MEM - 3)] = 1'b1;
        rwr = ($urandom_range(0, 3) != 0);
        step("rnd", rwr, ra, 8'($urandom), rap);
      end
      gap = $urandom_range(0, 30);
      for (int k = 0; k < gap; k++) begin
        if ($urandom_range(0, 7) == 0) rap = ~rap;
        step("rndq", 1'b0, '0, 8'h00, rap);
      end
      if (r == 30) async_reset("rndrst");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_instr_loader.md
Name: riscv_instr_loader

Overview:
Sits directly downstream of the leaf interface's RISC-V configuration port, between it and the picorv32 instruction memory. Consumes the byte-serial instruction stream (address, byte, write enable) and packs bytes into 32-bit word writes with byte strobes. Also owns core-reset sequencing: the core is held in reset while loading and released only after the load has settled and ap_start is high.

Parameters:
CFG_ADDR_BITS, 24, width of incoming byte address
MEM_ADDR_BITS, 14, word-address width of instruction memory (64 KiB)
IDLE_CYCLES, 16, quiet cycles after the last byte before the load is declared complete (≥2)
CNT_BITS, 24, width of the accepted-byte counter

Ports:
clk  input  1  user clock; single clock domain
resetn  input  1  asynchronous active-low reset
instr_config_addr  input  CFG_ADDR_BITS  byte address of incoming config byte
instr_config_din  input  8  config byte
instr_config_wr_en  input  1  byte valid, one byte per cycle, no backpressure
ap_start  input  1  run request from host
mem_addr  output  MEM_ADDR_BITS  word address of memory write
mem_wdata  output  32  packed write data
mem_wstrb  output  4  byte-lane enables, bit i = bits [8i+7:8i]
mem_we  output  1  one-cycle write pulse
core_resetn  output  1  active-low reset to picorv32
load_done  output  1  image loaded and settled
byte_count  output  CNT_BITS  accepted bytes since reset, saturating
addr_err  output  1  sticky; an out-of-range byte was dropped

Behaviour:
- Reset: all outputs 0 (core_resetn=0, held), staging empty, state IDLE, counters 0. All outputs registered.
- Byte mapping: lane = addr[1:0]; word = addr[MEM_ADDR_BITS+1:2]. If any addr bit above MEM_ADDR_BITS+1 is set, drop the byte, set addr_err (sticky until reset), and leave byte_count unchanged.
- Staging register holds one word address, 32-bit data and 4-bit strobe. An accepted byte to the staged word (or to an empty stage) merges into its lane; a repeat write to the same lane overwrites it.
- Flush (mem_we=1 for exactly one cycle, the cycle after the trigger):
  - the strobe becomes 4'hF: the completing byte is included, and the stage empties;
  - an accepted byte targets a different word: the old stage is flushed and the new byte is staged in the same cycle, with no lost byte and no bubble;
  - the idle counter reaches IDLE_CYCLES/2 with a non-empty stage.
- mem_addr/mem_wdata/mem_wstrb are valid only when mem_we=1; otherwise they hold their last values.
- byte_count increments per accepted byte and saturates at all-ones.
- Idle counter: cleared on any instr_config_wr_en (including dropped bytes); otherwise increments, saturating at IDLE_CYCLES.
- State machine:
  - IDLE: waits for the first wr_en, then goes to LOAD. With no image, ap_start is ignored and core_resetn stays 0.
  - LOAD: when idle counter = IDLE_CYCLES and the stage is empty, go to DONE; load_done=1 from the next cycle.
  - DONE: if ap_start=1, go to RUN; core_resetn=1 from the next cycle. A wr_en goes to LOAD and clears load_done.
  - RUN: if ap_start=0, go to DONE and drive core_resetn=0 next cycle. A wr_en goes to LOAD, drives core_resetn=0 and load_done=0 next cycle, and the byte is processed normally.
- ap_start high during LOAD has no effect until DONE is reached; the release then occurs one cycle after DONE.
- Asserting resetn mid-load discards the stage; a partially written memory is not rolled back.

Test Plan:
- Bytes 0x13,0x05,0x00,0x00 at addrs 0..3 on consecutive cycles → one mem_we, mem_addr=0, mem_wdata=0x00000513, mem_wstrb=4'hF, one cycle after the 4th byte; byte_count=4.
- Bytes at addr 5 (0xAA) then addr 8 (0xBB) back-to-back, then quiet → write addr 1, wdata[15:8]=0xAA, wstrb=4'b0010 the cycle after the addr-8 byte; then write addr 2, wstrb=4'b0001 after 8 idle cycles; load_done=1 after 16 idle cycles.
- Byte at addr 0x010000 (MEM_ADDR_BITS=14) → no mem_we, addr_err=1 and stays set, byte_count unchanged.
- Load completes, ap_start=1 → core_resetn rises one cycle after DONE; drop ap_start → core_resetn=0 next cycle; raise ap_start again → core_resetn=1.
- In RUN, a new byte arrives → core_resetn=0 and load_done=0 next cycle; reload completes, and core_resetn returns high with ap_start still 1.
- Repeated writes to addr 2 (0x11, then 0x22), then idle → a single write with wstrb=4'b0100 and wdata[23:16]=0x22; assert resetn mid-stage → no write, all outputs 0.
